ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline, sitting directly upstream of the memory stage and feeding its pipeline inputs. Computes the ALU result or effective address for every instruction and registers it with the instruction context. Hosts an iterative multiply/divide unit with HI/LO registers. Stalls the decode stage when an instruction needs an MDU result that is not yet ready.

## Interface
Parameters:
- MDU_ITERS, 32, iterations per multiply/divide; one bit per iteration.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  decode stage presents a real instruction; 0 means bubble.
- instr_in  in  32  instruction word; funct is instr_in[5:0], shamt is instr_in[10:6].
- imm_in  in  32  extended immediate.
- val_rs_in / val_rt_in  in  32  forwarded operands.
- rwd_in  in  5  destination register; 0 means no write.
- opcode_in  in  6  primary opcode.
- pc_in  in  32  instruction PC.
- stall_out  out  1  hold decode stage and PC; the current input must be re-presented.
- valid_out, instr_out, imm_out, val_rs_out, val_rt_out, rwd_out, opcode_out, pc_out  out  1/32/32/32/32/5/6/32  registered copies of the inputs, consumed by the memory stage.
- alu_res_out  out  32  registered result or memory address.

## Operation
- ALU, single cycle: addu/addiu, subu, and/andi, or/ori, xor, slt/sltu, sll/srl/sra (shamt), lui (imm<<16).
- lw/sw produce rs+imm.
- beq, j and unrecognised encodings produce 0.
- All arithmetic is modulo 2^32; overflow is ignored.
- MDU FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when a mult/multu/div/divu is accepted. Operands are latched; signed ops convert to magnitudes and record the result sign.
  - BUSY: shift-add multiply or restoring divide, one bit per cycle, for MDU_ITERS cycles.
  - BUSY -> DONE: sign fix-up, then write HI/LO. DONE -> IDLE after one cycle.
- Multiply results: HI=product[63:32], LO=product[31:0].
- Divide results: LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
- Divide by zero: LO=32'hFFFF_FFFF, HI=dividend. This is a defined result, not an exception.
- mthi/mtlo write HI/LO at the edge. mfhi/mflo place HI/LO on alu_res_out.
- Hazard rule: stall_out=1 combinationally when valid_in and the MDU is not IDLE, for either of these input groups:
  - mfhi/mflo/mthi/mtlo;
  - a new mult/div.
- While stalled, the output registers load a bubble: valid_out=0, rwd_out=0, instr_out=0. HI/LO and the FSM continue.
- Other instructions flow through unstalled while the MDU is busy.
- mult/div itself passes to the memory stage with rwd_out forced to 0.
- Bubble input (valid_in=0) still registers through; alu_res_out=0.

## Timing
- Latency: inputs at edge N appear on outputs after edge N+1.
- MDU: issue at edge N; BUSY for edges N+1..N+MDU_ITERS; HI/LO valid after edge N+MDU_ITERS+1. A dependent mfhi stalls until then.
- Reset (any time, including mid-BUSY):
  - all outputs 0 and valid_out=0;
  - HI=LO=0, FSM=IDLE;
  - any in-progress operation is discarded.
- stall_out is 0 during reset.
- Back-to-back mult after DONE: accepted in the IDLE cycle, with no extra gap.

## Configuration
- EX_DIV_EN defined: div/divu are executed as specified.
- EX_DIV_EN undefined: the divider datapath is removed. div/divu complete in one cycle with HI=LO=0, never enter BUSY and never stall. Multiply is unaffected.

## Structure
- Opcode/funct encodings, ALU op codes and MDU state encodings are constants in the shared def.v include.
- One sub-module, mdu_iter, holds the FSM, the operand/accumulator registers and HI/LO.
  - Inputs: start, op and operands.
  - Outputs: busy, hi, lo.
  - Also accepts HI/LO writes for mthi/mtlo.
- The ALU is combinational logic inside ex_stage.

## Test plan
- addu rs=32'h7FFF_FFFF, rt=1 -> alu_res_out=32'h8000_0000 one cycle later; rwd and pc propagate.
- mult rs=-3, rt=7, then mflo immediately -> stall_out high for MDU_ITERS+1 cycles with bubbles emitted; then alu_res_out=32'hFFFF_FFEB. A following mfhi gives 32'hFFFF_FFFF.
- div rs=-7, rt=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. divu by 0 with rs=5 -> LO=32'hFFFF_FFFF, HI=5.
- multu issued, then three addu -> the addu results flow with no stall while BUSY.
- rst_n pulsed low during BUSY -> outputs 0 immediately; a subsequent mfhi returns 0 with no stall.
- sw rs=32'h1000, imm=-4 -> alu_res_out=32'h0FFC, opcode_out=sw, val_rt_out=rt.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: opcode/funct values, ALU ops, MDU states.
// EX_DIV_EN selects whether div/divu use the iterative divider.
package ex_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_HI, ALU_LO
  } alu_op_e;

  typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_e;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
  } alu_ctl_t;

  function automatic alu_ctl_t decode_alu(input logic [5:0] opcode, input logic [5:0] funct);
    alu_ctl_t c;
    c = '{op: ALU_ZERO, use_imm: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: c.op = ALU_ADD;
          FN_SUBU: c.op = ALU_SUB;
          FN_AND:  c.op = ALU_AND;
          FN_OR:   c.op = ALU_OR;
          FN_XOR:  c.op = ALU_XOR;
          FN_SLT:  c.op = ALU_SLT;
          FN_SLTU: c.op = ALU_SLTU;
          FN_SLL:  c.op = ALU_SLL;
          FN_SRL:  c.op = ALU_SRL;
          FN_SRA:  c.op = ALU_SRA;
          FN_MFHI: c.op = ALU_HI;
          FN_MFLO: c.op = ALU_LO;
          default: c.op = ALU_ZERO;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: c = '{op: ALU_ADD, use_imm: 1'b1};
      OP_ANDI: c = '{op: ALU_AND, use_imm: 1'b1};
      OP_ORI:  c = '{op: ALU_OR,  use_imm: 1'b1};
      OP_LUI:  c = '{op: ALU_LUI, use_imm: 1'b1};
      default: c = '{op: ALU_ZERO, use_imm: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_stage_mdu_iter.sv
// Iterative multiply/divide unit with HI/LO; one result bit per BUSY cycle.
// The restoring divider exists only when EX_DIV_EN is defined.
module mdu_iter
  import ex_stage_pkg::*;
#(
  parameter int MDU_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(MDU_ITERS + 1);

  mdu_state_e    state;
  logic [CW-1:0] cnt;
  logic          is_div, neg_q;
  logic [31:0]   mcand;
  logic [63:0]   acc;
  logic          signed_op;
  logic [31:0]   a_mag, b_mag;
  logic [32:0]   mul_sum;
  logic [63:0]   mul_next, prod_fix;
`ifdef EX_DIV_EN
  logic          neg_r, div_zero;
  logic [32:0]   div_sh, div_diff;
  logic [63:0]   div_next;
  logic [31:0]   q_fix, r_fix;
`endif

  assign busy      = (state != MDU_IDLE);
  assign signed_op = ~op[0];
  assign a_mag     = (signed_op && a[31]) ? -a : a;
  assign b_mag     = (signed_op && b[31]) ? -b : b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    prod_fix = neg_q ? -acc : acc;
`ifdef EX_DIV_EN
    div_sh   = {acc[63:32], acc[31]};
    div_diff = div_sh - {1'b0, mcand};
    div_next = {div_diff[32] ? div_sh[31:0] : div_diff[31:0], acc[30:0], ~div_diff[32]};
    q_fix    = neg_q ? -acc[31:0] : acc[31:0];
    r_fix    = neg_r ? -acc[63:32] : acc[63:32];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MDU_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
`ifdef EX_DIV_EN
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      // Direct HI/LO writes; a completing operation in DONE overrides them
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
      case (state)
        MDU_IDLE: begin
          if (start) begin
            state  <= MDU_BUSY;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= signed_op & (a[31] ^ b[31]);
            mcand  <= op[1] ? b_mag : a_mag;
            acc    <= {32'd0, op[1] ? a_mag : b_mag};
`ifdef EX_DIV_EN
            neg_r    <= signed_op & a[31];
            div_zero <= (b == 32'd0);
`endif
          end
        end
        MDU_BUSY: begin
`ifdef EX_DIV_EN
          acc <= is_div ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          cnt <= cnt + 1'b1;
          if (cnt == CW'(MDU_ITERS - 1)) state <= MDU_DONE;
        end
        MDU_DONE: begin
          state <= MDU_IDLE;
          if (is_div) begin
`ifdef EX_DIV_EN
            lo <= div_zero ? 32'hFFFF_FFFF : q_fix;
            hi <= r_fix;
`else
            lo <= 32'd0;
            hi <= 32'd0;
`endif
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU, MDU hazard stall and pipeline register.
// EX_DIV_EN enables the iterative divider; otherwise div/divu clear HI/LO in one cycle.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MDU_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] val_rs_in,
  input  logic [31:0] val_rt_in,
  input  logic [4:0]  rwd_in,
  input  logic [5:0]  opcode_in,
  input  logic [31:0] pc_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] imm_out,
  output logic [31:0] val_rs_out,
  output logic [31:0] val_rt_out,
  output logic [4:0]  rwd_out,
  output logic [5:0]  opcode_out,
  output logic [31:0] pc_out,
  output logic [31:0] alu_res_out
);

  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        is_rtype, is_mult, is_div, is_hilo, is_start;
  logic        mdu_busy, mdu_start, accept, div_clear, wr_hi, wr_lo;
  logic [31:0] wr_data, hi, lo, op_b, alu_res;
  alu_ctl_t    ctl;

  assign funct    = instr_in[5:0];
  assign shamt    = instr_in[10:6];
  assign is_rtype = (opcode_in == OP_RTYPE);
  assign is_mult  = is_rtype && (funct == FN_MULT || funct == FN_MULTU);
  assign is_div   = is_rtype && (funct == FN_DIV || funct == FN_DIVU);
  assign is_hilo  = is_rtype && (funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});

`ifdef EX_DIV_EN
  assign is_start  = is_mult | is_div;
  assign div_clear = 1'b0;
`else
  assign is_start  = is_mult;
  assign div_clear = accept & is_div;
`endif

  assign stall_out = valid_in & mdu_busy & (is_hilo | is_start);
  assign accept    = valid_in & ~stall_out;
  assign mdu_start = accept & is_start;
  assign wr_hi     = (accept & is_rtype & (funct == FN_MTHI)) | div_clear;
  assign wr_lo     = (accept & is_rtype & (funct == FN_MTLO)) | div_clear;
  assign wr_data   = div_clear ? 32'd0 : val_rs_in;

  mdu_iter #(.MDU_ITERS(MDU_ITERS)) u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mdu_start),
    .op      (funct[1:0]),
    .a       (val_rs_in),
    .b       (val_rt_in),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .busy    (mdu_busy),
    .hi      (hi),
    .lo      (lo)
  );

  always_comb begin
    ctl     = decode_alu(opcode_in, funct);
    op_b    = ctl.use_imm ? imm_in : val_rt_in;
    alu_res = 32'd0;
    case (ctl.op)
      ALU_ADD:  alu_res = val_rs_in + op_b;
      ALU_SUB:  alu_res = val_rs_in - op_b;
      ALU_AND:  alu_res = val_rs_in & op_b;
      ALU_OR:   alu_res = val_rs_in | op_b;
      ALU_XOR:  alu_res = val_rs_in ^ op_b;
      ALU_SLT:  alu_res = {31'd0, $signed(val_rs_in) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, val_rs_in < op_b};
      ALU_SLL:  alu_res = val_rt_in << shamt;
      ALU_SRL:  alu_res = val_rt_in >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(val_rt_in) >>> shamt);
      ALU_LUI:  alu_res = {imm_in[15:0], 16'd0};
      ALU_HI:   alu_res = hi;
      ALU_LO:   alu_res = lo;
      default:  alu_res = 32'd0;
    endcase
  end

  // A stalled cycle emits an all-zero bubble to the memory stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || stall_out) begin
      valid_out   <= 1'b0;
      instr_out   <= '0;
      imm_out     <= '0;
      val_rs_out  <= '0;
      val_rt_out  <= '0;
      rwd_out     <= '0;
      opcode_out  <= '0;
      pc_out      <= '0;
      alu_res_out <= '0;
    end else begin
      valid_out   <= valid_in;
      instr_out   <= instr_in;
      imm_out     <= imm_in;
      val_rs_out  <= val_rs_in;
      val_rt_out  <= val_rt_in;
      rwd_out     <= (is_mult || is_div) ? 5'd0 : rwd_in;
      opcode_out  <= opcode_in;
      pc_out      <= pc_in;
      alu_res_out <= valid_in ? alu_res : 32'd0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage; honours EX_DIV_EN for div/divu expectations.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int ITERS = 32;
`ifdef EX_DIV_EN
  localparam int DIV_STALLS = ITERS + 1;
`else
  localparam int DIV_STALLS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] instr_in, imm_in, val_rs_in, val_rt_in, pc_in;
  logic [4:0]  rwd_in;
  logic [5:0]  opcode_in;
  logic        stall_out, valid_out;
  logic [31:0] instr_out, imm_out, val_rs_out, val_rt_out, pc_out, alu_res_out;
  logic [4:0]  rwd_out;
  logic [5:0]  opcode_out;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] res;
    logic [4:0]  rwd;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [31:0] rs, rt, imm, res;
  } alu_vec_t;

  exp_t        sb[$];
  alu_vec_t    tbl[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] pc = 32'h0000_0100;

  always #5 clk = ~clk;

  ex_stage #(.MDU_ITERS(ITERS)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_in(instr_in),
    .imm_in(imm_in), .val_rs_in(val_rs_in), .val_rt_in(val_rt_in),
    .rwd_in(rwd_in), .opcode_in(opcode_in), .pc_in(pc_in),
    .stall_out(stall_out), .valid_out(valid_out), .instr_out(instr_out),
    .imm_out(imm_out), .val_rs_out(val_rs_out), .val_rt_out(val_rt_out),
    .rwd_out(rwd_out), .opcode_out(opcode_out), .pc_out(pc_out),
    .alu_res_out(alu_res_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "/valid"}, {31'd0, valid_out}, {31'd0, e.valid});
      check({e.tag, "/res"},   alu_res_out, e.res);
      check({e.tag, "/rwd"},   {27'd0, rwd_out}, {27'd0, e.rwd});
      check({e.tag, "/pc"},    pc_out, e.pc);
    end
  endtask

  // Drive one cycle, check stall before the edge and the registered result after it
  task automatic applyStimulus(input string tag, input logic v, input logic [5:0] op,
                               input logic [5:0] fn, input logic [4:0] sh,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] imm, input logic [4:0] rwd,
                               input logic exp_stall, input logic [31:0] exp_res);
    exp_t e;
    logic muldiv;
    valid_in  = v;
    opcode_in = op;
    instr_in  = {op, 15'd0, sh, fn};
    val_rs_in = rs;
    val_rt_in = rt;
    imm_in    = imm;
    rwd_in    = rwd;
    pc_in     = pc;
    #1;
    check({tag, "/stall"}, {31'd0, stall_out}, {31'd0, exp_stall});
    muldiv = (op == OP_RTYPE) && (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    e.tag   = tag;
    e.valid = exp_stall ? 1'b0 : v;
    e.res   = exp_stall ? 32'd0 : exp_res;
    e.rwd   = (exp_stall || muldiv) ? 5'd0 : rwd;
    e.pc    = exp_stall ? 32'd0 : pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    if (!exp_stall) pc = pc + 32'd4;
  endtask

  task automatic mduRead(input string tag, input logic [5:0] fn, input logic [4:0] rwd,
                         input int n_stall, input logic [31:0] exp_res);
    for (int i = 0; i < n_stall; i++)
      applyStimulus({tag, "_stalled"}, 1'b1, OP_RTYPE, fn, 5'd0, 32'd0, 32'd0, 32'd0, rwd, 1'b1, 32'd0);
    applyStimulus(tag, 1'b1, OP_RTYPE, fn, 5'd0, 32'd0, 32'd0, 32'd0, rwd, 1'b0, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; instr_in = '0; imm_in = '0; val_rs_in = '0;
    val_rt_in = '0; rwd_in = '0; opcode_in = '0; pc_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/valid", {31'd0, valid_out}, 32'd0);
    check("reset/res", alu_res_out, 32'd0);
    check("reset/stall", {31'd0, stall_out}, 32'd0);
    rst_n = 1'b1;

    applyStimulus("addu_ovf", 1'b1, OP_RTYPE, FN_ADDU, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd3, 1'b0, 32'h8000_0000);
    applyStimulus("sw_addr", 1'b1, OP_SW, 6'd0, 5'd0, 32'h0000_1000, 32'hCAFE_0055, 32'hFFFF_FFFC, 5'd0, 1'b0, 32'h0000_0FFC);
    check("sw/opcode", {26'd0, opcode_out}, {26'd0, OP_SW});
    check("sw/val_rt", val_rt_out, 32'hCAFE_0055);

    applyStimulus("mult", 1'b1, OP_RTYPE, FN_MULT, 5'd0, 32'hFFFF_FFFD, 32'd7, 32'd0, 5'd5, 1'b0, 32'd0);
    mduRead("mflo_mult", FN_MFLO, 5'd8, ITERS + 1, 32'hFFFF_FFEB);
    mduRead("mfhi_mult", FN_MFHI, 5'd9, 0, 32'hFFFF_FFFF);

    applyStimulus("div", 1'b1, OP_RTYPE, FN_DIV, 5'd0, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd1, 1'b0, 32'd0);
`ifdef EX_DIV_EN
    mduRead("mflo_div", FN_MFLO, 5'd8, DIV_STALLS, 32'hFFFF_FFFD);
    mduRead("mfhi_div", FN_MFHI, 5'd9, 0, 32'hFFFF_FFFF);
`else
    mduRead("mflo_div", FN_MFLO, 5'd8, DIV_STALLS, 32'd0);
    mduRead("mfhi_div", FN_MFHI, 5'd9, 0, 32'd0);
`endif

    applyStimulus("mtlo", 1'b1, OP_RTYPE, FN_MTLO, 5'd0, 32'h1357_2468, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    applyStimulus("divu0", 1'b1, OP_RTYPE, FN_DIVU, 5'd0, 32'd5, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
`ifdef EX_DIV_EN
    mduRead("mflo_divu0", FN_MFLO, 5'd8, DIV_STALLS, 32'hFFFF_FFFF);
    mduRead("mfhi_divu0", FN_MFHI, 5'd9, 0, 32'd5);
`else
    mduRead("mflo_divu0", FN_MFLO, 5'd8, DIV_STALLS, 32'd0);
    mduRead("mfhi_divu0", FN_MFHI, 5'd9, 0, 32'd0);
`endif

    applyStimulus("multu", 1'b1, OP_RTYPE, FN_MULTU, 5'd0, 32'd3, 32'd4, 32'd0, 5'd0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus("addu_busy", 1'b1, OP_RTYPE, FN_ADDU, 5'd0, 32'd10 * i, 32'd7, 32'd0, 5'd2, 1'b0, 32'd10 * i + 32'd7);
    mduRead("mflo_multu", FN_MFLO, 5'd8, ITERS + 1 - 3, 32'd12);
    mduRead("mfhi_multu", FN_MFHI, 5'd9, 0, 32'd0);
    applyStimulus("mult_b2b", 1'b1, OP_RTYPE, FN_MULT, 5'd0, 32'd3, 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b0, 32'd0);
    mduRead("mflo_b2b", FN_MFLO, 5'd8, ITERS + 1, 32'hFFFF_FFFD);

    applyStimulus("mthi", 1'b1, OP_RTYPE, FN_MTHI, 5'd0, 32'h0000_1234, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    mduRead("mfhi_mthi", FN_MFHI, 5'd9, 0, 32'h0000_1234);
    applyStimulus("bubble", 1'b0, OP_RTYPE, FN_ADDU, 5'd0, 32'd11, 32'd22, 32'd0, 5'd4, 1'b0, 32'd0);

    tbl.push_back('{"subu", OP_RTYPE, FN_SUBU, 5'd0, 32'h8000_00F0, 32'h0000_0FF0, 32'd0, 32'h7FFF_F100});
    tbl.push_back('{"and",  OP_RTYPE, FN_AND,  5'd0, 32'h8000_00F0, 32'h0000_0FF0, 32'd0, 32'h0000_00F0});
    tbl.push_back('{"or",   OP_RTYPE, FN_OR,   5'd0, 32'h8000_00F0, 32'h0000_0FF0, 32'd0, 32'h8000_0FF0});
    tbl.push_back('{"xor",  OP_RTYPE, FN_XOR,  5'd0, 32'h8000_00F0, 32'h0000_0FF0, 32'd0, 32'h8000_0F00});
    tbl.push_back('{"slt",  OP_RTYPE, FN_SLT,  5'd0, 32'h8000_00F0, 32'h0000_0FF0, 32'd0, 32'd1});
    tbl.push_back('{"sltu", OP_RTYPE, FN_SLTU, 5'd0, 32'h8000_00F0, 32'h0000_0FF0, 32'd0, 32'd0});
    tbl.push_back('{"sll",  OP_RTYPE, FN_SLL,  5'd4, 32'h8000_00F0, 32'h0000_0FF0, 32'd0, 32'h0000_FF00});
    tbl.push_back('{"srl",  OP_RTYPE, FN_SRL,  5'd4, 32'h8000_00F0, 32'h0000_0FF0, 32'd0, 32'h0000_00FF});
    tbl.push_back('{"sra",  OP_RTYPE, FN_SRA,  5'd4, 32'd0, 32'h8000_00F0, 32'd0, 32'hF800_000F});
    tbl.push_back('{"lui",  OP_LUI,   6'd0,    5'd0, 32'd0, 32'd0, 32'h0000_1234, 32'h1234_0000});
    tbl.push_back('{"ori",  OP_ORI,   6'd0,    5'd0, 32'h8000_00F0, 32'd0, 32'h0000_1234, 32'h8000_12F4});
    tbl.push_back('{"andi", OP_ANDI,  6'd0,    5'd0, 32'h8000_00F0, 32'd0, 32'h0000_1234, 32'h0000_0030});
    tbl.push_back('{"addiu",OP_ADDIU, 6'd0,    5'd0, 32'h8000_00F0, 32'd0, 32'h0000_1234, 32'h8000_1324});
    tbl.push_back('{"lw",   OP_LW,    6'd0,    5'd0, 32'h8000_00F0, 32'd0, 32'h0000_1234, 32'h8000_1324});
    tbl.push_back('{"beq",  OP_BEQ,   6'd0,    5'd0, 32'd5, 32'd5, 32'h0000_0010, 32'd0});
    tbl.push_back('{"j",    OP_J,     6'd0,    5'd0, 32'd5, 32'd5, 32'h0000_0010, 32'd0});
    tbl.push_back('{"bad_op", 6'h3F,  6'd0,    5'd0, 32'd5, 32'd5, 32'h0000_0010, 32'd0});
    tbl.push_back('{"bad_fn", OP_RTYPE, 6'h3F, 5'd0, 32'd5, 32'd5, 32'd0, 32'd0});
    foreach (tbl[i])
      applyStimulus(tbl[i].tag, 1'b1, tbl[i].op, tbl[i].fn, tbl[i].sh, tbl[i].rs, tbl[i].rt,
                    tbl[i].imm, 5'd9, 1'b0, tbl[i].res);

    applyStimulus("mult_rst", 1'b1, OP_RTYPE, FN_MULT, 5'd0, 32'd5, 32'd6, 32'd0, 5'd0, 1'b0, 32'd0);
    applyStimulus("addu_rst", 1'b1, OP_RTYPE, FN_ADDU, 5'd0, 32'd1, 32'd2, 32'd0, 5'd6, 1'b0, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_busy/valid", {31'd0, valid_out}, 32'd0);
    check("rst_busy/res", alu_res_out, 32'd0);
    check("rst_busy/rwd", {27'd0, rwd_out}, 32'd0);
    check("rst_busy/pc", pc_out, 32'd0);
    check("rst_busy/stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mduRead("mfhi_after_rst", FN_MFHI, 5'd9, 0, 32'd0);
    mduRead("mflo_after_rst", FN_MFLO, 5'd8, 0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
